// File: rtl/tq_pkg.sv
// tq_pkg -- shared definitions for the 4x4 streaming forward transform.
//   TQ_IN_W    : default signed residual sample width
//   tq_mode_e  : butterfly selection (integer DCT or Hadamard)
//   tq_bank_e  : life cycle of one transpose-buffer bank
package tq_pkg;

   localparam int TQ_IN_W = 9;

   typedef enum logic {
      TQ_MODE_DCT = 1'b0,
      TQ_MODE_HAD = 1'b1
   } tq_mode_e;

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } tq_bank_e;

endpackage

// File: rtl/tq_butterfly4.sv
// tq_butterfly4 -- combinational 4-point 1-D butterfly (integer DCT or Hadamard).
// Ports:
//   i_vec  [4*W-1:0]     : four signed W-bit inputs, lane k = e[k]
//   i_mode               : TQ_MODE_DCT or TQ_MODE_HAD
//   o_vec  [4*(W+3)-1:0] : four signed (W+3)-bit outputs, lane k = d[k]
// The inputs are sign-extended by three bits, which covers the largest
// gain of either butterfly (sum of |coefficients| = 6), so no overflow.
module tq_butterfly4
   import tq_pkg::*;
#(
   parameter int W = TQ_IN_W
) (
   input  logic [4*W-1:0]     i_vec,
   input  tq_mode_e           i_mode,
   output logic [4*(W+3)-1:0] o_vec
);

   localparam int OW = W + 3;

   logic signed [OW-1:0] w_e [4];
   logic signed [OW-1:0] w_d [4];
   logic signed [OW-1:0] w_t0;
   logic signed [OW-1:0] w_t1;
   logic signed [OW-1:0] w_t2;
   logic signed [OW-1:0] w_t3;

   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign w_e[k] = {{3{i_vec[k*W+W-1]}}, i_vec[k*W +: W]};
      assign o_vec[k*OW +: OW] = w_d[k];
   end

   assign w_t0 = w_e[0] + w_e[3];
   assign w_t1 = w_e[1] + w_e[2];
   assign w_t2 = w_e[1] - w_e[2];
   assign w_t3 = w_e[0] - w_e[3];

   always_comb begin
      w_d[0] = w_t0 + w_t1;
      w_d[2] = w_t0 - w_t1;
      if (i_mode == TQ_MODE_HAD) begin
         w_d[1] = w_t3 + w_t2;
         w_d[3] = w_t3 - w_t2;
      end else begin
         w_d[1] = (w_t3 <<< 1) + w_t2;
         w_d[3] = w_t3 - (w_t2 <<< 1);
      end
   end

endmodule

// File: rtl/tq_dct_4x4_stream.sv
// tq_dct_4x4_stream -- streaming 4x4 forward integer DCT / Hadamard.
// Ports:
//   clk, rst      : single clock, synchronous active-high reset
//   in_valid_i    : row_i / mode_i valid        in_ready_o : row accepted this cycle
//   mode_i        : 0 = DCT, 1 = Hadamard, taken from row 0 of each block
//   row_i         : one row, lane k = s[r][k] (signed IN_W)
//   out_valid_o   : out_col_o valid             out_ready_i : consumer takes column
//   out_col_o     : lane k = d[j][k] (signed OUT_W), j = out_idx_o
//   out_last_o    : marks j = 3
// Configuration macro: TQ_DCT_HADAMARD_EN enables per-block Hadamard mode;
// without it mode_i is ignored and the block is DCT only.
// Rows are stored raw in a two-bank buffer; both butterfly stages run on
// the read side, so the transpose between them is pure wiring. Row 3 of a
// block is bypassed from row_i so column 0 can be registered on the same
// edge that accepts row 3.
module tq_dct_4x4_stream
   import tq_pkg::*;
#(
   parameter int IN_W  = TQ_IN_W,
   parameter int OUT_W = IN_W + 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic               mode_i,
   input  logic [4*IN_W-1:0]  row_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [4*OUT_W-1:0] out_col_o,
   output logic [1:0]         out_idx_o,
   output logic               out_last_o
);

   localparam int H_W = IN_W + 3;

   tq_bank_e           r_state [2];
   tq_bank_e           w_state_nxt [2];
   logic               r_wr_bank;
   logic [1:0]         r_wr_row;
   logic               r_rd_bank;
   logic [1:0]         r_rd_col;
   logic [4*IN_W-1:0]  r_mem [2][4];
   logic               r_vld_p1;
   logic [4*OUT_W-1:0] r_col_p1;
   logic [1:0]         r_idx_p1;
   logic               r_last_p1;
   logic               r_bank_p1;

   logic               w_in_fire;
   logic               w_out_fire;
   logic               w_bypass;
   logic               w_rd_avail;
   logic               w_load;
   tq_mode_e           w_rd_mode;
   logic [4*IN_W-1:0]  w_rd_row [4];
   logic [4*H_W-1:0]   w_h [4];
   logic [4*OUT_W-1:0] w_v [4];

   assign in_ready_o = !rst && ((r_state[r_wr_bank] == BANK_EMPTY) ||
                                (r_state[r_wr_bank] == BANK_FILLING));
   assign w_in_fire  = in_valid_i && in_ready_o;
   assign w_out_fire = r_vld_p1 && out_ready_i;
   // Read bank is still being filled and its last row arrives this cycle.
   assign w_bypass   = w_in_fire && (r_wr_bank == r_rd_bank) && (r_wr_row == 2'd3);
   assign w_rd_avail = (r_state[r_rd_bank] == BANK_FULL) ||
                       (r_state[r_rd_bank] == BANK_DRAINING) || w_bypass;
   assign w_load     = w_rd_avail && (!r_vld_p1 || out_ready_i);

`ifdef TQ_DCT_HADAMARD_EN
   tq_mode_e r_mode [2];

   always_ff @(posedge clk) begin
      if (w_in_fire && (r_wr_row == 2'd0)) begin
         r_mode[r_wr_bank] <= tq_mode_e'(mode_i);
      end
   end

   assign w_rd_mode = r_mode[r_rd_bank];
`else
   logic w_mode_unused;
   assign w_mode_unused = mode_i;
   assign w_rd_mode     = TQ_MODE_DCT;
`endif

   // ---- stage p0: row write into the current write bank ----
   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         r_mem[r_wr_bank][r_wr_row] <= row_i;
      end
   end

   // Horizontal butterflies on the four rows of the read bank.
   for (genvar r = 0; r < 4; r++) begin : g_row
      if (r == 3) begin : g_byp
         assign w_rd_row[r] = w_bypass ? row_i : r_mem[r_rd_bank][r];
      end else begin : g_mem
         assign w_rd_row[r] = r_mem[r_rd_bank][r];
      end
      tq_butterfly4 #(.W(IN_W)) u_hor (
         .i_vec  (w_rd_row[r]),
         .i_mode (w_rd_mode),
         .o_vec  (w_h[r])
      );
   end

   // Vertical butterflies: column j gathers horizontal frequency j of each row.
   for (genvar j = 0; j < 4; j++) begin : g_col
      tq_butterfly4 #(.W(H_W)) u_ver (
         .i_vec  ({w_h[3][j*H_W +: H_W], w_h[2][j*H_W +: H_W],
                   w_h[1][j*H_W +: H_W], w_h[0][j*H_W +: H_W]}),
         .i_mode (w_rd_mode),
         .o_vec  (w_v[j])
      );
   end

   // Bank life cycle; the three updates never target the same bank together
   // except fill-complete plus first read, where DRAINING must win.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         w_state_nxt[b] = r_state[b];
         if (w_in_fire && (r_wr_bank == 1'(b))) begin
            w_state_nxt[b] = (r_wr_row == 2'd3) ? BANK_FULL : BANK_FILLING;
         end
         if (w_load && (r_rd_col == 2'd0) && (r_rd_bank == 1'(b))) begin
            w_state_nxt[b] = BANK_DRAINING;
         end
         if (w_out_fire && r_last_p1 && (r_bank_p1 == 1'(b))) begin
            w_state_nxt[b] = BANK_EMPTY;
         end
      end
   end

   // ---- stage p1: registered output column ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state[0] <= BANK_EMPTY;
         r_state[1] <= BANK_EMPTY;
         r_wr_bank  <= 1'b0;
         r_wr_row   <= 2'd0;
         r_rd_bank  <= 1'b0;
         r_rd_col   <= 2'd0;
         r_vld_p1   <= 1'b0;
         r_col_p1   <= '0;
         r_idx_p1   <= 2'd0;
         r_last_p1  <= 1'b0;
         r_bank_p1  <= 1'b0;
      end else begin
         r_state[0] <= w_state_nxt[0];
         r_state[1] <= w_state_nxt[1];
         if (w_in_fire) begin
            r_wr_row <= r_wr_row + 2'd1;
            if (r_wr_row == 2'd3) begin
               r_wr_bank <= ~r_wr_bank;
            end
         end
         if (w_load) begin
            r_rd_col  <= r_rd_col + 2'd1;
            if (r_rd_col == 2'd3) begin
               r_rd_bank <= ~r_rd_bank;
            end
            r_vld_p1  <= 1'b1;
            r_col_p1  <= w_v[r_rd_col];
            r_idx_p1  <= r_rd_col;
            r_last_p1 <= (r_rd_col == 2'd3);
            r_bank_p1 <= r_rd_bank;
         end else if (out_ready_i) begin
            r_vld_p1  <= 1'b0;
         end
      end
   end

   assign out_valid_o = r_vld_p1;
   assign out_col_o   = r_col_p1;
   assign out_idx_o   = r_idx_p1;
   assign out_last_o  = r_last_p1;

endmodule

// File: tb/tb_tq_dct_4x4_stream.sv
// tb_tq_dct_4x4_stream -- self-checking bench for tq_dct_4x4_stream.
// Blocks are described as plain integer matrices; expected columns are
// computed as matrix products C * S^T-style sums from the transform matrices.
module tb_tq_dct_4x4_stream;

   localparam int IN_W  = 9;
   localparam int OUT_W = IN_W + 6;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid_i;
   logic               in_ready_o;
   logic               mode_i;
   logic [4*IN_W-1:0]  row_i;
   logic               out_valid_o;
   logic               out_ready_i;
   logic [4*OUT_W-1:0] out_col_o;
   logic [1:0]         out_idx_o;
   logic               out_last_o;

   tq_dct_4x4_stream #(.IN_W(IN_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .mode_i      (mode_i),
      .row_i       (row_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_col_o   (out_col_o),
      .out_idx_o   (out_idx_o),
      .out_last_o  (out_last_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   int blk_s [16][4][4];
   bit blk_m [16];

   logic [4*OUT_W-1:0] obs_col [$];
   logic [1:0]         obs_idx [$];
   bit                 obs_last [$];
   int first_valid_cyc, row3_cyc, ready_drops, first_drop_cyc, hold_viol;
   bit timed_out;

   // ---------------- reference model ----------------
   function automatic int cm(bit m, int a, int k);
      int dct [4][4];
      int had [4][4];
      dct = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
      had = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};
      return m ? had[a][k] : dct[a][k];
   endfunction

   function automatic bit eff_mode(int b);
`ifdef TQ_DCT_HADAMARD_EN
      return blk_m[b];
`else
      return 1'b0;
`endif
   endfunction

   // Column j of block b: lane i = sum_r C[i][r] * (sum_k C[j][k] * s[r][k]).
   function automatic logic [4*OUT_W-1:0] exp_col(int b, int j);
      bit m;
      int h [4];
      int v;
      logic [4*OUT_W-1:0] res;
      m = eff_mode(b);
      for (int r = 0; r < 4; r++) begin
         h[r] = 0;
         for (int k = 0; k < 4; k++) h[r] += cm(m, j, k) * blk_s[b][r][k];
      end
      for (int i = 0; i < 4; i++) begin
         v = 0;
         for (int r = 0; r < 4; r++) v += cm(m, i, r) * h[r];
         res[i*OUT_W +: OUT_W] = OUT_W'(v);
      end
      return res;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic gen_random(input int nb);
      for (int b = 0; b < nb; b++) begin
         for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
               blk_s[b][r][k] = int'($urandom_range(0, 511)) - 256;
         blk_m[b] = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic set_const(input int b, input int val, input bit m);
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            blk_s[b][r][k] = val;
      blk_m[b] = m;
   endtask

   // rdy_mode: 0 always ready, 1 random, 2 stalled for cycles 5..14, other = 0
   task automatic drive(input int row_n, input int total, input bit gaps,
                        input int rdy_mode, input int cyc);
      int b, r;
      b = row_n / 4;
      r = row_n % 4;
      in_valid_i = (row_n < total) && (!gaps || ($urandom_range(0, 3) != 0));
      if (row_n < total) begin
         for (int k = 0; k < 4; k++) row_i[k*IN_W +: IN_W] = IN_W'(blk_s[b][r][k]);
         mode_i = (r == 0) ? blk_m[b] : 1'($urandom_range(0, 1));
      end
      case (rdy_mode)
         0: out_ready_i = 1'b1;
         1: out_ready_i = ($urandom_range(0, 2) != 0);
         2: out_ready_i = !((cyc >= 5) && (cyc < 15));
         default: out_ready_i = 1'b0;
      endcase
   endtask

   // Streams blocks 0..nb-1 and records every transferred column.
   task automatic run_blocks(input int nb, input int rdy_mode, input bit gaps);
      int row_n, total, cyc;
      bit in_f, out_f, p_vld, p_rdy, p_last;
      logic [4*OUT_W-1:0] p_col;
      logic [1:0] p_idx;
      obs_col.delete();
      obs_idx.delete();
      obs_last.delete();
      first_valid_cyc = -1; row3_cyc = -1; ready_drops = 0;
      first_drop_cyc = -1; hold_viol = 0; timed_out = 0;
      total = nb * 4; row_n = 0; cyc = 0; p_vld = 0; p_rdy = 1;
      p_col = '0; p_idx = 2'd0; p_last = 0;
      drive(row_n, total, gaps, rdy_mode, cyc);
      while (((row_n < total) || (obs_col.size() < total)) && !timed_out) begin
         if (p_vld && !p_rdy && ((out_valid_o !== 1'b1) || (out_col_o !== p_col) ||
                                 (out_idx_o !== p_idx) || (out_last_o !== p_last)))
            hold_viol++;
         in_f  = in_valid_i && in_ready_o;
         out_f = out_valid_o && out_ready_i;
         if (out_valid_o && (first_valid_cyc < 0)) first_valid_cyc = cyc;
         if ((row_n < total) && !in_ready_o) begin
            ready_drops++;
            if (first_drop_cyc < 0) first_drop_cyc = cyc;
         end
         if (in_f && (row_n == 3)) row3_cyc = cyc;
         if (out_f) begin
            obs_col.push_back(out_col_o);
            obs_idx.push_back(out_idx_o);
            obs_last.push_back(out_last_o);
         end
         p_vld = out_valid_o; p_rdy = out_ready_i;
         p_col = out_col_o; p_idx = out_idx_o; p_last = out_last_o;
         @(posedge clk); #1;
         cyc++;
         if (in_f) row_n++;
         drive(row_n, total, gaps, rdy_mode, cyc);
         if (cyc >= 3000) timed_out = 1;
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b0; mode_i = 1'b0;
      row_i = {4*IN_W{1'b1}};
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_cmp++; if (in_ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready_o); end
      n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid_o); end
      n_cmp++; if (out_col_o !== '0) begin n_bad++; $display("FAIL rst_out_col: got %h want 0", out_col_o); end
      n_cmp++; if (out_idx_o !== 2'd0) begin n_bad++; $display("FAIL rst_out_idx: got %0d want 0", out_idx_o); end
      n_cmp++; if (out_last_o !== 1'b0) begin n_bad++; $display("FAIL rst_out_last: got %b want 0", out_last_o); end
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      rst = 1'b0;
      #1;
      n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready_o); end
   endtask

   task automatic test_dc_ones();
      logic [4*OUT_W-1:0] want0;
      int got;
      set_const(0, 1, 1'b0);
      run_blocks(1, 0, 1'b0);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL dc_timeout: got %0d cols want 4", obs_col.size()); end
      want0 = '0;
      want0[OUT_W-1:0] = OUT_W'(16);
      for (int c = 0; c < 4; c++) begin
         n_cmp++;
         if (c >= obs_col.size()) begin
            n_bad++; $display("FAIL dc_col%0d: got nothing", c);
         end else if ((obs_col[c] !== ((c == 0) ? want0 : '0)) || (obs_idx[c] !== 2'(c)) ||
                      (obs_last[c] !== (c == 3))) begin
            got = int'($signed(obs_col[c][OUT_W-1:0]));
            n_bad++; $display("FAIL dc_col%0d: got %h (lane0 %0d) idx %0d last %0b, want lane0 %0d idx %0d last %0b",
                              c, obs_col[c], got, obs_idx[c], obs_last[c], (c == 0) ? 16 : 0, c, c == 3);
         end
      end
   endtask

   task automatic test_ramp_row();
      int t_dct [4];
      int t_had [4];
      int want, got;
      t_dct = '{10, -7, 0, -1};
`ifdef TQ_DCT_HADAMARD_EN
      t_had = '{10, -4, 0, -2};
`else
      t_had = '{10, -7, 0, -1};
`endif
      for (int b = 0; b < 2; b++) begin
         set_const(b, 0, 1'(b));
         for (int k = 0; k < 4; k++) blk_s[b][0][k] = k + 1;
      end
      run_blocks(2, 0, 1'b0);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL ramp_timeout: got %0d cols want 8", obs_col.size()); end
      for (int c = 0; c < 8; c++) begin
         want = (c < 4) ? t_dct[c % 4] : t_had[c % 4];
         n_cmp++;
         if (c >= obs_col.size()) begin
            n_bad++; $display("FAIL ramp_col%0d: got nothing want %0d", c, want);
         end else begin
            got = int'($signed(obs_col[c][OUT_W-1:0]));
            if (got != want) begin
               n_bad++; $display("FAIL ramp_col%0d lane0: got %0d want %0d", c, got, want);
            end
         end
      end
   endtask

   task automatic test_extremes();
      int want, got;
      set_const(0, 255, 1'b0);
      set_const(1, -256, 1'b0);
      run_blocks(2, 0, 1'b0);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL ext_timeout: got %0d cols want 8", obs_col.size()); end
      for (int c = 0; c < 8 && c < obs_col.size(); c++) begin
         for (int i = 0; i < 4; i++) begin
            want = ((c % 4 == 0) && (i == 0)) ? ((c < 4) ? 4080 : -4096) : 0;
            got  = int'($signed(obs_col[c][i*OUT_W +: OUT_W]));
            n_cmp++;
            if (got != want) begin
               n_bad++; $display("FAIL ext_col%0d_lane%0d: got %0d want %0d", c, i, got, want);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      gen_random(8);
      run_blocks(8, 0, 1'b0);
      n_cmp++; if (obs_col.size() != 32) begin n_bad++; $display("FAIL b2b_count: got %0d want 32", obs_col.size()); end
      n_cmp++; if (ready_drops != 0) begin n_bad++; $display("FAIL b2b_ready: got %0d low cycles want 0", ready_drops); end
      n_cmp++; if (first_valid_cyc != row3_cyc + 1) begin n_bad++; $display("FAIL b2b_latency: got valid at %0d want %0d", first_valid_cyc, row3_cyc + 1); end
      for (int c = 0; c < 32; c++) begin
         n_cmp++;
         if (c >= obs_col.size()) begin
            n_bad++; $display("FAIL b2b_col%0d: got nothing want %h", c, exp_col(c / 4, c % 4));
         end else if ((obs_col[c] !== exp_col(c / 4, c % 4)) || (obs_idx[c] !== 2'(c % 4)) ||
                      (obs_last[c] !== (c % 4 == 3))) begin
            n_bad++; $display("FAIL b2b_col%0d: got %h idx %0d last %0b want %h idx %0d last %0b",
                              c, obs_col[c], obs_idx[c], obs_last[c], exp_col(c / 4, c % 4), c % 4, c % 4 == 3);
         end
      end
   endtask

   task automatic test_backpressure();
      gen_random(3);
      run_blocks(3, 2, 1'b0);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL bp_timeout: got %0d cols want 12", obs_col.size()); end
      n_cmp++; if (hold_viol != 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_viol); end
      n_cmp++; if (first_drop_cyc != 8) begin n_bad++; $display("FAIL bp_ready_drop: got first low at %0d want 8", first_drop_cyc); end
      for (int c = 0; c < 12; c++) begin
         n_cmp++;
         if (c >= obs_col.size()) begin
            n_bad++; $display("FAIL bp_col%0d: got nothing want %h", c, exp_col(c / 4, c % 4));
         end else if ((obs_col[c] !== exp_col(c / 4, c % 4)) || (obs_idx[c] !== 2'(c % 4)) ||
                      (obs_last[c] !== (c % 4 == 3))) begin
            n_bad++; $display("FAIL bp_col%0d: got %h idx %0d last %0b want %h idx %0d last %0b",
                              c, obs_col[c], obs_idx[c], obs_last[c], exp_col(c / 4, c % 4), c % 4, c % 4 == 3);
         end
      end
   endtask

   task automatic test_random_flow();
      gen_random(6);
      run_blocks(6, 1, 1'b1);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL flow_timeout: got %0d cols want 24", obs_col.size()); end
      n_cmp++; if (hold_viol != 0) begin n_bad++; $display("FAIL flow_hold: got %0d unstable cycles want 0", hold_viol); end
      for (int c = 0; c < 24; c++) begin
         n_cmp++;
         if (c >= obs_col.size()) begin
            n_bad++; $display("FAIL flow_col%0d: got nothing want %h", c, exp_col(c / 4, c % 4));
         end else if ((obs_col[c] !== exp_col(c / 4, c % 4)) || (obs_idx[c] !== 2'(c % 4)) ||
                      (obs_last[c] !== (c % 4 == 3))) begin
            n_bad++; $display("FAIL flow_col%0d: got %h idx %0d last %0b want %h idx %0d last %0b",
                              c, obs_col[c], obs_idx[c], obs_last[c], exp_col(c / 4, c % 4), c % 4, c % 4 == 3);
         end
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      gen_random(3);
      // One complete block parked behind a stalled output, then rows 0-2 of the next.
      for (int n = 0; n < 7; n++) begin
         drive(n, 12, 1'b0, 3, 0);
         @(posedge clk); #1;
      end
      in_valid_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready_i = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid_o !== 1'b0) seen++;
         @(posedge clk); #1;
      end
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rmid_no_output: got %0d valid cycles want 0", seen); end
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            blk_s[0][r][k] = blk_s[2][r][k];
      blk_m[0] = blk_m[2];
      run_blocks(1, 0, 1'b0);
      n_cmp++; if (obs_col.size() != 4) begin n_bad++; $display("FAIL rmid_count: got %0d want 4", obs_col.size()); end
      for (int c = 0; c < 4; c++) begin
         n_cmp++;
         if (c >= obs_col.size()) begin
            n_bad++; $display("FAIL rmid_col%0d: got nothing want %h", c, exp_col(0, c));
         end else if ((obs_col[c] !== exp_col(0, c)) || (obs_idx[c] !== 2'(c)) ||
                      (obs_last[c] !== (c == 3))) begin
            n_bad++; $display("FAIL rmid_col%0d: got %h idx %0d last %0b want %h idx %0d last %0b",
                              c, obs_col[c], obs_idx[c], obs_last[c], exp_col(0, c), c, c == 3);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid_i = 1'b0;
      out_ready_i = 1'b0;
      mode_i = 1'b0;
      row_i = '0;
      test_reset();
      test_dc_ones();
      test_ramp_row();
      test_extremes();
      test_back_to_back();
      test_backpressure();
      test_random_flow();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
